// File: rtl/vec_alu_pkg.sv
// Shared definitions for the vector ALU sequencer: opcodes, FSM states,
// flag bit positions and the lane fixed-point multiply helper.
package vec_alu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;

  localparam int FLAG_CARRY = 0;
  localparam int FLAG_ZERO  = 1;
  localparam int FLAG_NEG   = 2;
  localparam int FLAG_OVF   = 3;

  // Zero is AND-accumulated, so it starts set; the others start clear.
  localparam logic [3:0] FLAGS_INIT = 4'b0010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  // High byte pair gives the upper 7 bits, low byte pair the upper byte of its product.
  function automatic logic [15:0] lane_mul(input logic [15:0] a, input logic [15:0] b);
    logic [15:0] hi_prod;
    logic [15:0] lo_prod;
    hi_prod = {9'd0, a[14:8]} * {9'd0, b[14:8]};
    lo_prod = {8'd0, a[7:0]} * {8'd0, b[7:0]};
    return {1'b0, hi_prod[6:0], lo_prod[15:8]};
  endfunction

endpackage

// File: rtl/vec_alu_sequencer_if.sv
// Request/response handshake bundle between a vector ALU client and the sequencer.
interface vec_alu_sequencer_if #(
  parameter int LANES = 4,
  parameter int WIDTH = 16
);
  logic                   req_valid;
  logic                   req_ready;
  logic [2:0]             req_opcode;
  logic [LANES*WIDTH-1:0] req_a;
  logic [LANES*WIDTH-1:0] req_b;
  logic                   resp_valid;
  logic                   resp_ready;
  logic [LANES*WIDTH-1:0] resp_result;
  logic [3:0]             resp_flags;
  logic                   busy;

  modport master (
    output req_valid, req_opcode, req_a, req_b, resp_ready,
    input  req_ready, resp_valid, resp_result, resp_flags, busy
  );

  modport slave (
    input  req_valid, req_opcode, req_a, req_b, resp_ready,
    output req_ready, resp_valid, resp_result, resp_flags, busy
  );
endinterface

// File: rtl/vec_lane_alu.sv
// Combinational single-lane ALU: computes one 16-bit lane result and its flags.
module vec_lane_alu
  import vec_alu_pkg::*;
(
  input  logic [2:0]  opcode,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] result,
  output logic [3:0]  flags
);

  // Lane operation select
  always_comb begin
    result = 16'h0000;
    case (opcode)
      OP_ADD:  result = a + b;
      OP_SUB:  result = a - b;
      OP_MUL:  result = lane_mul(a, b);
      default: result = 16'h0000;
    endcase
  end

  // Lane flag derivation
  always_comb begin
    flags             = 4'b0000;
    flags[FLAG_CARRY] = ~a[15] & ~b[15] & result[15];
    flags[FLAG_ZERO]  = (result == 16'h0000);
    flags[FLAG_NEG]   = result[15];
    flags[FLAG_OVF]   = (result > 16'h7FFF);
  end

endmodule

// File: rtl/vec_alu_sequencer.sv
// Vector ALU sequencer: latches a request, runs one lane per cycle through a
// shared lane ALU, accumulates flags and holds the response until accepted.
module vec_alu_sequencer
  import vec_alu_pkg::*;
#(
  parameter int LANES = 4,
  parameter int WIDTH = 16
)(
  input  logic               clk,
  input  logic               rst_n,
  vec_alu_sequencer_if.slave bus
);

  localparam int CW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [CW-1:0] LAST_LANE = CW'(LANES - 1);

  state_t                 state_r;
  state_t                 state_nxt_s;
  logic [CW-1:0]          cnt_r;
  logic [2:0]             op_r;
  logic [LANES*WIDTH-1:0] a_r;
  logic [LANES*WIDTH-1:0] b_r;
  logic [LANES*WIDTH-1:0] result_r;
  logic [3:0]             flags_r;
  logic                   req_ready_r;
  logic                   resp_valid_r;
  logic                   busy_r;
  logic [WIDTH-1:0]       lane_a_s;
  logic [WIDTH-1:0]       lane_b_s;
  logic [WIDTH-1:0]       lane_res_s;
  logic [3:0]             lane_flags_s;
  logic                   accept_s;

  assign accept_s = (state_r == ST_IDLE) && bus.req_valid;
  assign lane_a_s = a_r[int'(cnt_r)*WIDTH +: WIDTH];
  assign lane_b_s = b_r[int'(cnt_r)*WIDTH +: WIDTH];

  vec_lane_alu u_lane_alu (
    .opcode (op_r),
    .a      (lane_a_s),
    .b      (lane_b_s),
    .result (lane_res_s),
    .flags  (lane_flags_s)
  );

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.req_valid) begin
          state_nxt_s = ST_EXEC;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_EXEC: begin
        if (cnt_r == LAST_LANE) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_EXEC;
        end
      end
      ST_DONE: begin
        if (bus.resp_ready) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_DONE;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Operand latch, lane counter, result and flag accumulation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r    <= '0;
      op_r     <= 3'b000;
      a_r      <= '0;
      b_r      <= '0;
      result_r <= '0;
      flags_r  <= 4'b0000;
    end else if (accept_s) begin
      cnt_r    <= '0;
      op_r     <= bus.req_opcode;
      a_r      <= bus.req_a;
      b_r      <= bus.req_b;
      result_r <= '0;
      flags_r  <= FLAGS_INIT;
    end else if (state_r == ST_EXEC) begin
      result_r[int'(cnt_r)*WIDTH +: WIDTH] <= lane_res_s;
      flags_r[FLAG_CARRY] <= flags_r[FLAG_CARRY] | lane_flags_s[FLAG_CARRY];
      flags_r[FLAG_ZERO]  <= flags_r[FLAG_ZERO]  & lane_flags_s[FLAG_ZERO];
      flags_r[FLAG_NEG]   <= flags_r[FLAG_NEG]   | lane_flags_s[FLAG_NEG];
      flags_r[FLAG_OVF]   <= flags_r[FLAG_OVF]   | lane_flags_s[FLAG_OVF];
      // Counter parks on the last lane rather than wrapping.
      if (cnt_r != LAST_LANE) begin
        cnt_r <= cnt_r + CW'(1);
      end else begin
        cnt_r <= cnt_r;
      end
    end else begin
      cnt_r    <= cnt_r;
      result_r <= result_r;
      flags_r  <= flags_r;
    end
  end

  // Handshake/status outputs registered from the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_ready_r  <= 1'b1;
      resp_valid_r <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      req_ready_r  <= (state_nxt_s == ST_IDLE);
      resp_valid_r <= (state_nxt_s == ST_DONE);
      busy_r       <= (state_nxt_s != ST_IDLE);
    end
  end

  assign bus.req_ready   = req_ready_r;
  assign bus.resp_valid  = resp_valid_r;
  assign bus.busy        = busy_r;
  assign bus.resp_result = result_r;
  assign bus.resp_flags  = flags_r;

endmodule

// File: tb/tb_vec_alu_sequencer.sv
// Self-checking bench: directed and randomized vector operations compared
// against a lane-by-lane arithmetic reference model.
module tb_vec_alu_sequencer;

  localparam int LANES = 4;
  localparam int WIDTH = 16;
  localparam int VW    = LANES * WIDTH;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  logic [15:0] a_l [LANES];
  logic [15:0] b_l [LANES];

  vec_alu_sequencer_if #(.LANES(LANES), .WIDTH(WIDTH)) bus ();

  vec_alu_sequencer #(.LANES(LANES), .WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference lane computation in plain integer arithmetic.
  function automatic int lane_model(input int op, input int a, input int b);
    case (op)
      0:       return (a + b) % 65536;
      1:       return (a - b + 65536) % 65536;
      2:       return ((((a / 256) % 128) * ((b / 256) % 128)) % 128) * 256
                      + ((a % 256) * (b % 256)) / 256;
      default: return 0;
    endcase
  endfunction

  task automatic model(input int op, output logic [63:0] res, output logic [3:0] fl);
    bit c, z, n, v;
    c = 0; z = 1; n = 0; v = 0;
    res = '0;
    for (int i = 0; i < LANES; i++) begin
      int a, b, r;
      a = int'(a_l[i]);
      b = int'(b_l[i]);
      r = lane_model(op, a, b);
      res[16*i +: 16] = 16'(r);
      if (a < 32768 && b < 32768 && r >= 32768) c = 1;
      if (r != 0) z = 0;
      if (r >= 32768) n = 1;
      if (r > 32767) v = 1;
    end
    fl = {v, n, z, c};
  endtask

  task automatic fill(input logic [15:0] a, input logic [15:0] b);
    for (int i = 0; i < LANES; i++) begin
      a_l[i] = a;
      b_l[i] = b;
    end
  endtask

  task automatic run_op(input logic [2:0] op, input string tag, input bit bp);
    logic [63:0] er;
    logic [3:0]  ef;
    int          edges;
    model(int'(op), er, ef);
    for (int i = 0; i < LANES; i++) begin
      bus.req_a[16*i +: 16] = a_l[i];
      bus.req_b[16*i +: 16] = b_l[i];
    end
    bus.req_opcode = op;
    bus.req_valid  = 1'b1;
    check({tag, " req_ready idle"}, 64'(bus.req_ready), 64'd1);
    tick();
    bus.req_valid = 1'b0;
    edges = 1;
    check({tag, " busy exec"}, 64'(bus.busy), 64'd1);
    check({tag, " req_ready exec"}, 64'(bus.req_ready), 64'd0);
    while (!bus.resp_valid && edges < 20) begin
      if (bp && edges == 2) begin
        bus.req_valid  = 1'b1;
        bus.req_a      = ~bus.req_a;
        bus.req_b      = ~bus.req_b;
        bus.req_opcode = op ^ 3'b001;
      end else begin
        bus.req_valid = 1'b0;
      end
      bus.resp_ready = bp ? 1'b1 : 1'($urandom_range(0, 1));
      tick();
      edges++;
    end
    bus.req_valid = 1'b0;
    check({tag, " latency"}, 64'(edges), 64'(LANES + 1));
    check({tag, " result"}, bus.resp_result, er);
    check({tag, " flags"}, 64'(bus.resp_flags), 64'(ef));
    if (bp) begin
      for (int k = 0; k < 3; k++) begin
        bus.resp_ready = 1'b0;
        tick();
        check({tag, " hold valid"}, 64'(bus.resp_valid), 64'd1);
        check({tag, " hold result"}, bus.resp_result, er);
        check({tag, " hold flags"}, 64'(bus.resp_flags), 64'(ef));
        check({tag, " hold req_ready"}, 64'(bus.req_ready), 64'd0);
      end
    end
    bus.resp_ready = 1'b1;
    tick();
    bus.resp_ready = 1'b0;
    check({tag, " post valid"}, 64'(bus.resp_valid), 64'd0);
    check({tag, " post req_ready"}, 64'(bus.req_ready), 64'd1);
    check({tag, " post busy"}, 64'(bus.busy), 64'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " resp_valid"}, 64'(bus.resp_valid), 64'd0);
    check({tag, " req_ready"}, 64'(bus.req_ready), 64'd1);
    check({tag, " busy"}, 64'(bus.busy), 64'd0);
    check({tag, " result"}, bus.resp_result, 64'd0);
    check({tag, " flags"}, 64'(bus.resp_flags), 64'd0);
  endtask

  initial begin
    n_vec          = 0;
    n_err          = 0;
    rst_n          = 1'b1;
    bus.req_valid  = 1'b0;
    bus.req_opcode = 3'b000;
    bus.req_a      = '0;
    bus.req_b      = '0;
    bus.resp_ready = 1'b0;

    // Power-on reset
    #2 rst_n = 1'b0;
    tick();
    tick();
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // Directed operations
    fill(16'h0100, 16'h0200);
    run_op(3'b000, "add_all", 1'b0);
    fill(16'h1234, 16'h1234);
    run_op(3'b001, "sub_zero", 1'b0);
    a_l[2] = 16'h1235;
    run_op(3'b001, "sub_lane2", 1'b0);
    fill(16'h0280, 16'h0300);
    run_op(3'b010, "mul_all", 1'b0);
    a_l[0] = 16'h7FFF;
    b_l[0] = 16'h7FFF;
    run_op(3'b010, "mul_max", 1'b0);
    fill(16'h0000, 16'h0000);
    a_l[1] = 16'h7FFF;
    b_l[1] = 16'h0001;
    run_op(3'b000, "add_ovf", 1'b0);
    fill(16'hBEEF, 16'h1234);
    run_op(3'b110, "invalid_op", 1'b0);

    // Backpressure with an ignored mid-EXEC request
    fill(16'h4321, 16'h0F0F);
    run_op(3'b000, "backpressure", 1'b1);

    // Reset on the second EXEC cycle aborts the operation
    fill(16'h1111, 16'h2222);
    for (int i = 0; i < LANES; i++) begin
      bus.req_a[16*i +: 16] = a_l[i];
      bus.req_b[16*i +: 16] = b_l[i];
    end
    bus.req_opcode = 3'b000;
    bus.req_valid  = 1'b1;
    tick();
    bus.req_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    check_reset_outputs("abort");
    tick();
    check_reset_outputs("abort_held");
    fill(16'h0F00, 16'h00F0);
    rst_n = 1'b1;
    run_op(3'b000, "after_abort", 1'b0);

    // Randomized operations
    for (int t = 0; t < 24; t++) begin
      int sel;
      for (int i = 0; i < LANES; i++) begin
        sel = int'($urandom_range(0, 3));
        a_l[i] = (sel == 0) ? 16'h7FFF : 16'($urandom);
        b_l[i] = (sel == 1) ? 16'h0000 : 16'($urandom);
      end
      run_op(3'($urandom_range(0, 7)), $sformatf("rand%0d", t), 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
